// File: rtl/endec_job_scheduler_pkg.sv
// Shared constants, FSM encoding and small helpers for the endec job scheduler.
package endec_job_scheduler_pkg;

   localparam int DEF_CFG_W   = 28;
   localparam int DEF_STATE_W = 8;
   localparam int POLY_W      = 27;
   localparam int DEF_TIMEOUT = 4096;
   localparam int MAX_CH      = 4;

   typedef logic [2:0] fsm_t;

   localparam fsm_t ST_IDLE    = 3'd0;
   localparam fsm_t ST_LOAD    = 3'd1;
   localparam fsm_t ST_RUN     = 3'd2;
   localparam fsm_t ST_DRAIN   = 3'd3;
   localparam fsm_t ST_RELEASE = 3'd4;

   typedef struct packed {
      logic              code_rate;
      logic [POLY_W-1:0] gen_poly;
   } job_cfg_t;

   function automatic logic [MAX_CH-1:0] idx_to_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/endec_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after the pointer wins.
module endec_job_scheduler_rr_arbiter
   import endec_job_scheduler_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [1:0]        ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [1:0]        idx,
   output logic              any
);

   logic [MAX_CH-1:0] req_pad;
   logic              found;

   assign req_pad = MAX_CH'(req);
   assign any     = |req;

   // Cyclic scan starting at ptr+1; the pointer channel itself is checked last.
   always_comb begin
      logic [1:0] c;
      logic       hit;
      idx   = 2'd0;
      found = 1'b0;
      c     = 2'd0;
      hit   = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         c     = 2'((int'(ptr) + i) % NUM_CH);
         hit   = req_pad[c] & ~found;
         idx   = hit ? c : idx;
         found = found | hit;
      end
   end

   assign grant = NUM_CH'(idx_to_onehot(idx)) & {NUM_CH{found}};

endmodule

// File: rtl/endec_job_scheduler.sv
// Time-shares one endec core between NUM_CH buffered frame sources, sequencing
// core reset/enable/completion and chaining the encoder tail state per channel.
module endec_job_scheduler
   import endec_job_scheduler_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int CFG_W   = DEF_CFG_W,
   parameter int STATE_W = DEF_STATE_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      sys_clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         i_req,
   input  logic [NUM_CH-1:0]         i_sof,
   input  logic [NUM_CH*CFG_W-1:0]   i_cfg_flat,
   input  logic [NUM_CH*STATE_W-1:0] i_tail_flat,
   output logic [NUM_CH-1:0]         o_grant,
   output logic [1:0]                o_sel,
   output logic                      o_core_rst,
   output logic                      o_core_en,
   output logic                      o_code_rate,
   output logic [POLY_W-1:0]         o_gen_poly_flat,
   output logic [STATE_W-1:0]        o_prv_state,
   input  logic                      i_enc_done,
   input  logic                      i_dec_done,
   output logic                      o_tx_start,
   input  logic                      i_tx_done,
   output logic [NUM_CH-1:0]         o_done,
   output logic [NUM_CH-1:0]         o_timeout,
   output logic                      o_busy
);

   localparam int CNT_W = $clog2(TIMEOUT);

   fsm_t               state;
   logic [1:0]         ptr;
   logic               enc_seen;
   logic               dec_seen;
   logic [CNT_W-1:0]   run_cnt;
   logic [STATE_W-1:0] saved [MAX_CH];

   logic [NUM_CH-1:0]         arb_grant;
   logic [1:0]                arb_idx;
   logic                      arb_any;
   logic [MAX_CH-1:0]         sof_pad;
   logic [MAX_CH*CFG_W-1:0]   cfg_pad;
   logic [MAX_CH*STATE_W-1:0] tail_pad;
   job_cfg_t                  cfg_win;
   logic [STATE_W-1:0]        start_state;
   logic [STATE_W-1:0]        tail_sel;
   logic                      both_seen;
   logic                      run_expired;

   endec_job_scheduler_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req   (i_req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Padding to four channels keeps every 2-bit channel index exactly in range.
   assign sof_pad     = MAX_CH'(i_sof);
   assign cfg_pad     = (MAX_CH*CFG_W)'(i_cfg_flat);
   assign tail_pad    = (MAX_CH*STATE_W)'(i_tail_flat);
   assign cfg_win     = cfg_pad[arb_idx*CFG_W +: CFG_W];
   assign start_state = sof_pad[arb_idx] ? {STATE_W{1'b0}} : saved[arb_idx];
   assign tail_sel    = tail_pad[o_sel*STATE_W +: STATE_W];

   // A done pulse arriving in the current cycle counts as already latched.
   assign both_seen   = (enc_seen | i_enc_done) & (dec_seen | i_dec_done);
   assign run_expired = (run_cnt == CNT_W'(TIMEOUT - 1));

   // Job sequencing FSM; all core-facing and status outputs are registered here.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         ptr             <= 2'(NUM_CH - 1);
         enc_seen        <= 1'b0;
         dec_seen        <= 1'b0;
         run_cnt         <= '0;
         o_grant         <= '0;
         o_sel           <= 2'd0;
         o_core_rst      <= 1'b0;
         o_core_en       <= 1'b0;
         o_code_rate     <= 1'b0;
         o_gen_poly_flat <= '0;
         o_prv_state     <= '0;
         o_tx_start      <= 1'b0;
         o_done          <= '0;
         o_timeout       <= '0;
         o_busy          <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         o_done     <= '0;
         o_timeout  <= '0;
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  o_grant         <= arb_grant;
                  o_sel           <= arb_idx;
                  ptr             <= arb_idx;
                  o_code_rate     <= cfg_win.code_rate;
                  o_gen_poly_flat <= cfg_win.gen_poly;
                  o_prv_state     <= start_state;
                  o_busy          <= 1'b1;
                  state           <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               enc_seen   <= 1'b0;
               dec_seen   <= 1'b0;
               run_cnt    <= '0;
               o_core_rst <= 1'b1;
               o_core_en  <= 1'b1;
               state      <= ST_RUN;
            end
            ST_RUN: begin
               enc_seen <= enc_seen | i_enc_done;
               dec_seen <= dec_seen | i_dec_done;
               run_cnt  <= run_cnt + CNT_W'(1);
               if (both_seen) begin
                  o_core_en  <= 1'b0;
                  o_tx_start <= 1'b1;
                  state      <= ST_DRAIN;
               end else if (run_expired) begin
                  o_timeout  <= o_grant;
                  o_grant    <= '0;
                  o_core_rst <= 1'b0;
                  o_core_en  <= 1'b0;
                  state      <= ST_RELEASE;
               end
            end
            ST_DRAIN: begin
               if (i_tx_done) begin
                  o_done     <= o_grant;
                  o_grant    <= '0;
                  o_core_rst <= 1'b0;
                  state      <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               o_grant    <= '0;
               o_core_rst <= 1'b0;
               o_core_en  <= 1'b0;
               o_busy     <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

   // Per-channel encoder tail store; only a successfully drained job updates it.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_CH; i++) begin
            saved[i] <= '0;
         end
      end else if ((state == ST_DRAIN) && i_tx_done) begin
         saved[o_sel] <= tail_sel;
      end
   end

endmodule

// File: doc/endec_job_scheduler.md
Name: endec_job_scheduler

Overview:
- Shares one endec core between NUM_CH frame sources.
- Each source holds a fully buffered frame and raises a request. The scheduler grants sources round-robin, drives the source's per-channel config into the core, and sequences the core's reset, enable and completion.
- Hands each result to the TX path and keeps a per-channel encoder tail state, so consecutive frames of one stream chain without re-initialisation.
- Sits between the per-channel RX/TX buffers and the endec instance.

Parameters:
- NUM_CH, 2, number of requesting channels (2..4).
- CFG_W, 28, per-channel config width: {code_rate, gen_poly_flat[26:0]}.
- STATE_W, 8, encoder state register width (MAX_STATE_REG_NUM).
- TIMEOUT, 4096, max RUN cycles before the job is aborted.

Ports:
- sys_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_CH  per-channel frame-ready level; held until matching o_done/o_timeout.
- i_sof  in  NUM_CH  level, sampled at grant; 1 = first frame of stream, start from state 0.
- i_cfg_flat  in  NUM_CH*CFG_W  per-channel config.
- i_tail_flat  in  NUM_CH*STATE_W  per-channel final encoder state of the buffered frame (last STATE_W input bits).
- o_grant  out  NUM_CH  one-hot granted channel, 0 when idle.
- o_sel  out  2  index of granted channel, used for the data muxes.
- o_core_rst  out  1  core reset, active-low (0 = core held in reset).
- o_core_en  out  1  core enable.
- o_code_rate  out  1  muxed config bit.
- o_gen_poly_flat  out  27  muxed generator polynomials.
- o_prv_state  out  STATE_W  starting encoder state for the granted job.
- i_enc_done  in  1  core encoder done.
- i_dec_done  in  1  core decoder done.
- o_tx_start  out  1  one-cycle pulse: results valid, TX path may drain.
- i_tx_done  in  1  one-cycle pulse: TX path finished sending.
- o_done  out  NUM_CH  one-cycle completion pulse per channel.
- o_timeout  out  NUM_CH  one-cycle abort pulse per channel.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, async):
  - All outputs 0. FSM=IDLE. RR pointer=NUM_CH-1, so channel 0 wins first. Saved states=0. Done latches=0.
- FSM states: IDLE, LOAD, RUN, DRAIN, RELEASE.
- IDLE:
  - If any i_req, select the first requesting channel after the RR pointer (cyclic) and register o_grant/o_sel.
  - Update pointer to the winner. Go LOAD.
  - Arbitration is 1 cycle.
- LOAD (1 cycle):
  - o_core_rst=0, o_core_en=0. Config muxed from granted channel.
  - o_prv_state = 0 if i_sof[ch] else saved_state[ch].
  - Clear done latches and timeout counter. Go RUN.
- RUN:
  - o_core_rst=1, o_core_en=1. Latch i_enc_done and i_dec_done independently; they may arrive in different cycles.
  - When both latched (including same-cycle arrival), go DRAIN. Pulse o_tx_start on entry.
  - Counter reaching TIMEOUT-1 with either latch still clear: go RELEASE with abort flag.
- DRAIN:
  - o_core_rst=1, o_core_en=0, so core outputs are held. Wait for i_tx_done.
  - i_tx_done then: saved_state[ch] <= i_tail of ch. Go RELEASE.
- RELEASE (1 cycle):
  - Pulse o_done[ch], or o_timeout[ch] if aborted. Aborted jobs leave saved_state unchanged.
  - o_grant=0, o_core_rst=0. Go IDLE.
  - Minimum gap between grants is 2 cycles.
- Held inputs:
  - o_prv_state and config are held constant from LOAD through DRAIN, even if i_cfg/i_sof/i_tail change.
- i_req deassert while granted: ignored; the job runs to completion.
- Done signals outside RUN: ignored.
- i_tx_done outside DRAIN: ignored.
- o_tx_start is exactly one pulse per successful job; none on timeout.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 jobs.
- rst_n assertion mid-job: immediate return to reset values; saved states cleared.

Decomposition:
- Shared package: FSM state encoding, CFG_W, STATE_W, gen-poly width 27, TIMEOUT default.
- Sub-module rr_arbiter: request vector and pointer in, one-hot grant and index out, purely combinational. The scheduler registers its result.

Test Plan:
- Single request, i_req=01, i_sof=1, enc_done at RUN+5, dec_done at RUN+9, i_tx_done 3 cycles after o_tx_start:
  - o_grant=01 next cycle; LOAD shows o_core_rst=0 and o_prv_state=0.
  - o_tx_start pulses once; o_done=01 one cycle after i_tx_done.
- Chaining: same channel, i_tail=8'hA5, second frame with i_sof=0 -> o_prv_state=8'hA5 in LOAD.
- Contention: i_req=11 held continuously -> grant sequence 01,10,01,10; no channel granted twice in a row.
- Split done: enc_done and dec_done pulses 20 cycles apart -> one o_tx_start, after the later pulse only.
- Timeout: TIMEOUT=64, dec_done never arrives:
  - o_timeout pulses at RUN+64; no o_tx_start; saved_state unchanged; o_busy falls.
- Reset mid-RUN: rst_n low for 1 cycle -> all outputs 0 asynchronously; next job with i_sof=0 sees o_prv_state=0.
